// File: rtl/host_uart_cmd_pkg.sv
// Shared definitions for the host UART command path: command IDs, framing
// constants, decoder error codes and the decoder state encoding.
package host_uart_cmd_pkg;

   localparam logic [15:0] ID_ENCRYPT_ENABLE  = 16'h0001;
   localparam logic [15:0] ID_READ_YAW        = 16'h0002;
   localparam logic [15:0] ID_INVALID_COMMAND = 16'h0004;

   localparam logic [7:0] SOF_BYTE = 8'hA5;

   localparam logic [2:0] ERR_NONE    = 3'd0;
   localparam logic [2:0] ERR_LEN     = 3'd1;
   localparam logic [2:0] ERR_CSUM    = 3'd2;
   localparam logic [2:0] ERR_ID      = 3'd3;
   localparam logic [2:0] ERR_TIMEOUT = 3'd4;
   localparam logic [2:0] ERR_OVERRUN = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ID_HI   = 3'd1,
      ST_ID_LO   = 3'd2,
      ST_LEN     = 3'd3,
      ST_PAYLOAD = 3'd4,
`ifdef CMD_CHECKSUM_EN
      ST_CSUM    = 3'd5,
`endif
      ST_CHECK   = 3'd6,
      ST_HOLD    = 3'd7
   } state_t;

   // Only commands the controller can act on are passed through.
   function automatic logic is_known_id(input logic [15:0] id);
      return (id == ID_ENCRYPT_ENABLE) || (id == ID_READ_YAW);
   endfunction

endpackage

// File: rtl/host_uart_byte_timeout.sv
// Inter-byte timeout counter: clear reloads zero, run lets it count, and
// expired strobes on the idle clock that reaches TIMEOUT_CYCLES.
module host_uart_byte_timeout #(
   parameter int unsigned TIMEOUT_CYCLES = 100000
)(
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic run,
   output logic expired
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count;

   assign expired = run && !clear && (count == LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count <= '0;
      else if (clear || !run || expired)
         count <= '0;
      else
         count <= count + 1'b1;
   end

endmodule

// File: rtl/host_uart_command_dec.sv
// Host command frame decoder: SOF, ID_HI, ID_LO, LEN, payload and, when
// CMD_CHECKSUM_EN is defined, a trailing XOR checksum byte.
module host_uart_command_dec #(
   parameter int unsigned MAX_PAYLOAD_BYTES = 32,
   parameter int unsigned TIMEOUT_CYCLES    = 100000,
   parameter logic [7:0]  SOF_BYTE          = host_uart_cmd_pkg::SOF_BYTE
)(
   input  logic                           clk,
   input  logic                           reset,
   input  logic [7:0]                     rx_data,
   input  logic                           rx_valid,
   input  logic                           cmd_ack,
   output logic [15:0]                    cmd_id,
   output logic [7:0]                     cmd_len,
   output logic [8*MAX_PAYLOAD_BYTES-1:0] cmd_payload,
   output logic                           cmd_valid,
   output logic                           error,
   output logic [2:0]                     error_code,
   output logic                           busy
);

   import host_uart_cmd_pkg::*;

   localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD_BYTES);

   state_t     state, next_state;
   logic [7:0] byte_idx;
   logic       start_frame, cap_id_hi, cap_id_lo, cap_len, cap_pay;
   logic       frame_done, valid_set, valid_clr, err_set;
   logic [2:0] err_code_n;
   logic       tmo_run, tmo_expired;
`ifdef CMD_CHECKSUM_EN
   logic [7:0] csum;
`endif

   assign busy    = (state != ST_IDLE) && (state != ST_HOLD);
   assign tmo_run = busy && (state != ST_CHECK);

   host_uart_byte_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (clk),
      .reset  (reset),
      .clear  (rx_valid),
      .run    (tmo_run),
      .expired(tmo_expired)
   );

   // Byte-driven next-state logic; a pending command blocks new frames until acked.
   always_comb begin
      next_state  = state;
      start_frame = 1'b0;
      cap_id_hi   = 1'b0;
      cap_id_lo   = 1'b0;
      cap_len     = 1'b0;
      cap_pay     = 1'b0;
      frame_done  = 1'b0;
      valid_set   = 1'b0;
      valid_clr   = 1'b0;
      err_set     = 1'b0;
      err_code_n  = ERR_NONE;
      case (state)
         ST_IDLE: begin
            if (rx_valid && rx_data == SOF_BYTE) begin
               start_frame = 1'b1;
               next_state  = ST_ID_HI;
            end
         end
         ST_ID_HI: begin
            if (rx_valid) begin
               cap_id_hi  = 1'b1;
               next_state = ST_ID_LO;
            end
         end
         ST_ID_LO: begin
            if (rx_valid) begin
               cap_id_lo  = 1'b1;
               next_state = ST_LEN;
            end
         end
         ST_LEN: begin
            if (rx_valid) begin
               cap_len = 1'b1;
               if (rx_data > MAX_LEN) begin
                  err_set    = 1'b1;
                  err_code_n = ERR_LEN;
                  next_state = ST_IDLE;
               end else if (rx_data == 8'd0) begin
`ifdef CMD_CHECKSUM_EN
                  next_state = ST_CSUM;
`else
                  frame_done = 1'b1;
`endif
               end else begin
                  next_state = ST_PAYLOAD;
               end
            end
         end
         ST_PAYLOAD: begin
            if (rx_valid) begin
               cap_pay = 1'b1;
               if (byte_idx == cmd_len - 8'd1) begin
`ifdef CMD_CHECKSUM_EN
                  next_state = ST_CSUM;
`else
                  frame_done = 1'b1;
`endif
               end
            end
         end
`ifdef CMD_CHECKSUM_EN
         ST_CSUM: begin
            if (rx_valid) begin
               if (rx_data != csum) begin
                  err_set    = 1'b1;
                  err_code_n = ERR_CSUM;
                  next_state = ST_IDLE;
               end else begin
                  frame_done = 1'b1;
               end
            end
         end
`endif
         ST_CHECK, ST_HOLD: begin
            if (state == ST_CHECK)
               next_state = cmd_valid ? ST_HOLD : ST_IDLE;
            if (cmd_valid) begin
               if (cmd_ack) begin
                  valid_clr  = 1'b1;
                  next_state = ST_IDLE;
                  if (rx_valid && rx_data == SOF_BYTE) begin
                     start_frame = 1'b1;
                     next_state  = ST_ID_HI;
                  end
               end else if (rx_valid) begin
                  err_set    = 1'b1;
                  err_code_n = ERR_OVERRUN;
               end
            end
         end
         default: next_state = ST_IDLE;
      endcase

      // Validation happens as the last byte lands so cmd_valid shows in CHECK.
      if (frame_done) begin
         next_state = ST_CHECK;
         if (is_known_id(cmd_id)) begin
            valid_set = 1'b1;
         end else begin
            err_set    = 1'b1;
            err_code_n = ERR_ID;
         end
      end
      if (tmo_expired) begin
         err_set    = 1'b1;
         err_code_n = ERR_TIMEOUT;
         next_state = ST_IDLE;
      end
   end

   // Frame fields are captured in place; HOLD accepts no bytes so they stay stable.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         cmd_id      <= '0;
         cmd_len     <= '0;
         cmd_payload <= '0;
         cmd_valid   <= 1'b0;
         error       <= 1'b0;
         error_code  <= '0;
         byte_idx    <= '0;
`ifdef CMD_CHECKSUM_EN
         csum        <= '0;
`endif
      end else begin
         state <= next_state;
         error <= err_set;
         if (err_set)
            error_code <= err_code_n;
         if (start_frame) begin
            cmd_payload <= '0;
            byte_idx    <= '0;
`ifdef CMD_CHECKSUM_EN
            csum        <= '0;
`endif
         end
         if (cap_id_hi)
            cmd_id[15:8] <= rx_data;
         if (cap_id_lo)
            cmd_id[7:0] <= rx_data;
         if (cap_len)
            cmd_len <= rx_data;
         if (cap_pay) begin
            for (int i = 0; i < int'(MAX_PAYLOAD_BYTES); i++)
               if (byte_idx == 8'(i))
                  cmd_payload[8*i +: 8] <= rx_data;
            byte_idx <= byte_idx + 8'd1;
         end
`ifdef CMD_CHECKSUM_EN
         if (cap_id_hi || cap_id_lo || cap_len || cap_pay)
            csum <= csum ^ rx_data;
`endif
         if (valid_set)
            cmd_valid <= 1'b1;
         else if (valid_clr)
            cmd_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_host_uart_command_dec.sv
// Scoreboard bench for host_uart_command_dec: directed frames push expected
// commands/errors, a monitor pops them as the DUT presents them.
module tb_host_uart_command_dec;

   localparam int unsigned MAXP = 32;
   localparam int unsigned TMO  = 40;

   typedef struct {
      bit                  is_err;
      logic [2:0]          code;
      logic [15:0]         id;
      logic [7:0]          len;
      logic [8*MAXP-1:0]   payload;
   } exp_t;

   logic              clk;
   logic              reset;
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              cmd_ack;
   logic [15:0]       cmd_id;
   logic [7:0]        cmd_len;
   logic [8*MAXP-1:0] cmd_payload;
   logic              cmd_valid;
   logic              error;
   logic [2:0]        error_code;
   logic              busy;

   int checks = 0;
   int errors = 0;
   exp_t sb[$];
   logic [7:0] frm[$];

   host_uart_command_dec #(
      .MAX_PAYLOAD_BYTES(MAXP),
      .TIMEOUT_CYCLES   (TMO)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .cmd_ack    (cmd_ack),
      .cmd_id     (cmd_id),
      .cmd_len    (cmd_len),
      .cmd_payload(cmd_payload),
      .cmd_valid  (cmd_valid),
      .error      (error),
      .error_code (error_code),
      .busy       (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string name, input logic [8*MAXP-1:0] act,
                               input logic [8*MAXP-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic push_valid(input logic [15:0] id, input logic [7:0] len,
                             input logic [8*MAXP-1:0] payload);
      exp_t e;
      e.is_err = 1'b0; e.code = 3'd0; e.id = id; e.len = len; e.payload = payload;
      sb.push_back(e);
   endtask

   task automatic push_err(input logic [2:0] code);
      exp_t e;
      e.is_err = 1'b1; e.code = code; e.id = '0; e.len = '0; e.payload = '0;
      sb.push_back(e);
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   // Sends frm; with the checksum build, appends the XOR of all bytes after SOF
   // (or a deliberately wrong 00 when bad_csum is set).
   task automatic apply_stimulus(input bit bad_csum);
      logic [7:0] x;
      x = 8'h00;
      foreach (frm[i]) begin
         if (i > 0) x = x ^ frm[i];
         send_byte(frm[i]);
      end
`ifdef CMD_CHECKSUM_EN
      send_byte(bad_csum ? 8'h00 : x);
`else
      if (bad_csum) $display("[TB] note: checksum byte not used in this build (%0h)", x);
`endif
   endtask

   task automatic ack_cycle();
      cmd_ack = 1'b1;
      @(negedge clk);
      cmd_ack = 1'b0;
   endtask

   // Monitor: pops one expectation per cmd_valid rise or error pulse.
   initial begin
      logic prev_valid;
      exp_t e;
      prev_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_valid = 1'b0;
         end else begin
            if (cmd_valid && !prev_valid) begin
               if (sb.size() == 0) begin
                  checks++; errors++;
                  $display("[TB] FAIL sb_unexpected_valid: got cmd_id %0h, expected no command", cmd_id);
               end else begin
                  e = sb.pop_front();
                  check_output("sb_kind_valid", 0, e.is_err);
                  check_output("sb_cmd_id", cmd_id, e.id);
                  check_output("sb_cmd_len", cmd_len, e.len);
                  check_output("sb_cmd_payload", cmd_payload, e.payload);
               end
            end
            if (error) begin
               if (sb.size() == 0) begin
                  checks++; errors++;
                  $display("[TB] FAIL sb_unexpected_error: got code %0d, expected no error", error_code);
               end else begin
                  e = sb.pop_front();
                  check_output("sb_kind_error", 1, e.is_err);
                  check_output("sb_error_code", error_code, e.code);
               end
            end
            prev_valid = cmd_valid;
         end
      end
   end

   initial begin
      int n;
      reset    = 1'b1;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      cmd_ack  = 1'b0;
      repeat (2) @(negedge clk);
      check_output("reset_outputs",
                   {cmd_id, cmd_len, cmd_valid, error, error_code, busy}, '0);
      check_output("reset_payload", cmd_payload, '0);
      reset = 1'b0;
      @(negedge clk);

      // ENCRYPT_ENABLE, empty payload
      push_valid(16'h0001, 8'd0, '0);
      frm = '{8'hA5, 8'h00, 8'h01, 8'h00};
      apply_stimulus(0);
      check_output("latency_valid", cmd_valid, 1);
      repeat (3) @(negedge clk);
      check_output("hold_valid", cmd_valid, 1);
      check_output("hold_id", cmd_id, 16'h0001);
      ack_cycle();
      check_output("ack_drop_valid", cmd_valid, 0);
      check_output("ack_busy", busy, 0);

      // READ_YAW with four payload bytes
      push_valid(16'h0002, 8'd4, 256'h04030201);
      frm = '{8'hA5, 8'h00, 8'h02, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04};
      apply_stimulus(0);
      check_output("yaw_latency_valid", cmd_valid, 1);
      @(negedge clk);
      ack_cycle();

      // Unknown ID
      push_err(3'd3);
      frm = '{8'hA5, 8'h00, 8'h07, 8'h00};
      apply_stimulus(0);
      repeat (3) @(negedge clk);
      check_output("unknown_no_valid", cmd_valid, 0);

`ifdef CMD_CHECKSUM_EN
      push_err(3'd2);
      frm = '{8'hA5, 8'h00, 8'h02, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04};
      apply_stimulus(1);
      repeat (2) @(negedge clk);
      check_output("csum_no_valid", cmd_valid, 0);
`endif

      // Length 33 exceeds the maximum
      push_err(3'd1);
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02); send_byte(8'h21);
      check_output("len_err_pulse", error, 1);
      check_output("len_err_code", error_code, 3'd1);
      @(negedge clk);
      check_output("len_err_busy", busy, 0);

      // Stall mid-frame
      push_err(3'd4);
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
      check_output("tmo_busy_before", busy, 1);
      n = 0;
      while (!error && n < 4 * TMO) begin
         @(negedge clk);
         n++;
      end
      check_output("tmo_cycles", n, TMO);
      check_output("tmo_code", error_code, 3'd4);
      check_output("tmo_busy_after", busy, 0);
      @(negedge clk);

      // Overrun while holding, then ack together with a new SOF
      push_valid(16'h0001, 8'd0, '0);
      frm = '{8'hA5, 8'h00, 8'h01, 8'h00};
      apply_stimulus(0);
      @(negedge clk);
      push_err(3'd5);
      send_byte(8'h33);
      check_output("ovr_code", error_code, 3'd5);
      check_output("ovr_valid", cmd_valid, 1);
      check_output("ovr_id_len", {cmd_id, cmd_len}, {16'h0001, 8'd0});
      check_output("ovr_payload", cmd_payload, '0);
      push_valid(16'h0002, 8'd1, 256'h5A);
      cmd_ack  = 1'b1;
      rx_data  = 8'hA5;
      rx_valid = 1'b1;
      @(negedge clk);
      cmd_ack  = 1'b0;
      rx_valid = 1'b0;
      check_output("ackrx_busy", busy, 1);
      frm = '{8'h00, 8'h02, 8'h01, 8'h5A};
      foreach (frm[i]) send_byte(frm[i]);
`ifdef CMD_CHECKSUM_EN
      send_byte(8'h00 ^ 8'h02 ^ 8'h01 ^ 8'h5A);
`endif
      check_output("ackrx_valid", cmd_valid, 1);
      ack_cycle();

      // Reset mid-payload, then a clean frame
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02); send_byte(8'h04);
      send_byte(8'h01); send_byte(8'h02);
      reset = 1'b1;
      @(negedge clk);
      check_output("midrst_outputs",
                   {cmd_id, cmd_len, cmd_valid, error, error_code, busy}, '0);
      check_output("midrst_payload", cmd_payload, '0);
      reset = 1'b0;
      @(negedge clk);
      push_valid(16'h0002, 8'd4, 256'h04030201);
      frm = '{8'hA5, 8'h00, 8'h02, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04};
      apply_stimulus(0);
      check_output("postrst_valid", cmd_valid, 1);
      ack_cycle();

      repeat (4) @(negedge clk);
      check_output("sb_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
